// File: rtl/i2c_pkg.sv
// Shared definitions for the codec I2C target: FSM state type, R/W bit values
// and the codec register map.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEV,
        S_ACK_DEV,
        S_REG,
        S_ACK_REG,
        S_DATA,
        S_ACK_DATA,
        S_IGNORE
    } i2c_state_t;

    localparam logic I2C_WR_BIT = 1'b0;
    localparam logic I2C_RD_BIT = 1'b1;

    localparam logic [6:0] REG_LLINE_IN     = 7'h00;
    localparam logic [6:0] REG_RLINE_IN     = 7'h01;
    localparam logic [6:0] REG_LHP_OUT      = 7'h02;
    localparam logic [6:0] REG_RHP_OUT      = 7'h03;
    localparam logic [6:0] REG_ANALOG_PATH  = 7'h04;
    localparam logic [6:0] REG_DIGITAL_PATH = 7'h05;
    localparam logic [6:0] REG_POWER_DOWN   = 7'h06;
    localparam logic [6:0] REG_DIGITAL_IF   = 7'h07;
    localparam logic [6:0] REG_SAMPLING     = 7'h08;
    localparam logic [6:0] REG_ACTIVE       = 7'h09;
    localparam logic [6:0] REG_RESET        = 7'h0F;

endpackage

// File: rtl/i2c_line_cond.sv
// I2C line conditioner: 2-FF synchronizers, optional glitch filter
// (I2C_TARGET_GLITCH_FILTER_EN), and SCL edge / START / STOP detection.
module i2c_line_cond #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // Bit 0 = SCL, bit 1 = SDA; idle-high reset avoids false edges.
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic [1:0] w_cur;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {i_sda, i_scl};
            r_sync2 <= r_sync1;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] r_cnt [2];
    logic [1:0]    r_filt;

    // Output follows the input only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt <= '1;
            for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_cur = r_filt;
`else
    assign w_cur = r_sync2;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= '1;
        else          r_prev <= w_cur;
    end

    assign o_sda      = w_cur[1];
    assign o_scl_rise =  w_cur[0] & ~r_prev[0];
    assign o_scl_fall = ~w_cur[0] &  r_prev[0];
    assign o_start    = w_cur[0] & r_prev[0] & ~w_cur[1] &  r_prev[1];
    assign o_stop     = w_cur[0] & r_prev[0] &  w_cur[1] & ~r_prev[1];

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target modelling the audio codec register file; decodes
// {addr,W},{reg,d8},{data} writes. Optional glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_codec_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [6:0]  RESET_REG  = REG_RESET,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       CLOCK_50,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       bus_busy,
    output logic       err_pulse
);

    localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_line (
        .i_clk      (CLOCK_50),
        .i_rst_n    (iRST_N),
        .i_scl      (I2C_SCLK),
        .i_sda      (I2C_SDAT),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_t r_state, w_state_nxt;
    logic       r_sda_low, w_sda_low_nxt;
    logic [3:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [6:0] r_reg_idx;
    logic       r_d8;
    logic       r_busy;
    logic       r_wr_strobe, r_err;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic [8:0] r_regs [NUM_REGS];
    logic       w_byte_done, w_commit, w_latch_reg, w_cnt_clr, w_shifting;

    assign w_byte_done = w_scl_fall && (r_bitcnt == 4'd8);
    assign w_shifting  = w_scl_rise && (r_bitcnt != 4'd8) &&
                         (r_state == S_DEV || r_state == S_REG || r_state == S_DATA);

    // SDA drive lives in an async-reset flop so reset releases the bus at once.
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state   <= S_IDLE;
            r_sda_low <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sda_low <= w_sda_low_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sda_low_nxt = r_sda_low;
        w_commit      = 1'b0;
        w_latch_reg   = 1'b0;
        w_cnt_clr     = 1'b0;
        if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_low_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = S_DEV;
            w_sda_low_nxt = 1'b0;
            w_cnt_clr     = 1'b1;
        end else begin
            case (r_state)
                S_DEV: if (w_byte_done) begin
                    if (r_shift == {DEV_ADDR, I2C_WR_BIT}) begin
                        w_state_nxt   = S_ACK_DEV;
                        w_sda_low_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_IGNORE;
                    end
                end
                S_REG: if (w_byte_done) begin
                    w_state_nxt   = S_ACK_REG;
                    w_sda_low_nxt = 1'b1;
                    w_latch_reg   = 1'b1;
                end
                S_DATA: if (w_byte_done) begin
                    w_state_nxt   = S_ACK_DATA;
                    w_sda_low_nxt = 1'b1;
                    w_commit      = 1'b1;
                end
                S_ACK_DEV: if (w_scl_fall) begin
                    w_state_nxt   = S_REG;
                    w_sda_low_nxt = 1'b0;
                    w_cnt_clr     = 1'b1;
                end
                S_ACK_REG: if (w_scl_fall) begin
                    w_state_nxt   = S_DATA;
                    w_sda_low_nxt = 1'b0;
                    w_cnt_clr     = 1'b1;
                end
                S_ACK_DATA: if (w_scl_fall) begin
                    w_state_nxt   = S_IGNORE;
                    w_sda_low_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_reg_idx   <= '0;
            r_d8        <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_err       <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_stop)       r_busy <= 1'b0;
            else if (w_start) r_busy <= 1'b1;

            if (w_cnt_clr) begin
                r_bitcnt <= '0;
            end else if (w_shifting) begin
                r_shift  <= {r_shift[6:0], w_sda};
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if (w_latch_reg) begin
                r_reg_idx <= r_shift[7:1];
                r_d8      <= r_shift[0];
            end

            r_wr_strobe <= w_commit;
            r_err       <= 1'b0;
            if (w_commit) begin
                r_wr_addr <= r_reg_idx;
                r_wr_data <= {r_d8, r_shift};
                if (r_reg_idx == RESET_REG) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
                end else if (32'(r_reg_idx) < NUM_REGS) begin
                    r_regs[r_reg_idx[IDXW-1:0]] <= {r_d8, r_shift};
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign I2C_SDAT  = r_sda_low ? 1'b0 : 1'bz;
    assign rd_data   = (32'(rd_addr) < NUM_REGS) ? r_regs[rd_addr[IDXW-1:0]] : '0;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign bus_busy  = r_busy;
    assign err_pulse = r_err;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed self-checking bench for i2c_codec_target acting as an I2C master.
module tb_i2c_codec_target;

    localparam int Q = 10;  // quarter SCL bit period in CLOCK_50 cycles

    logic       CLOCK_50 = 1'b0;
    logic       iRST_N   = 1'b0;
    logic       scl      = 1'b1;
    logic       sda_low  = 1'b0;
    wire        sda_bus;
    logic [6:0] rd_addr  = '0;
    logic [8:0] rd_data;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       bus_busy;
    logic       err_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n_err    = 0;

    pullup pu_sda (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (wr_strobe === 1'b1) n_strobe <= n_strobe + 1;
        if (err_pulse === 1'b1) n_err    <= n_err + 1;
    end

    i2c_codec_target #(
        .DEV_ADDR  (7'h1A),
        .NUM_REGS  (16),
        .RESET_REG (7'h0F),
        .FILTER_LEN(4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .iRST_N   (iRST_N),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bus_busy (bus_busy),
        .err_pulse(err_pulse)
    );

    task automatic wait_q();
        repeat (Q) @(negedge CLOCK_50);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b1; wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        sda_low = 1'b0; wait_q(); wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i]; wait_q();
            scl = 1'b1;      wait_q(); wait_q();
            scl = 1'b0;      wait_q();
        end
    endtask

    task automatic ack_slot(output logic ack);
        sda_low = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        ack = (sda_bus === 1'b0);
        wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_slot(ack);
    endtask

    task automatic write3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          output logic [2:0] acks);
        i2c_start();
        send_byte(a, acks[2]);
        send_byte(b, acks[1]);
        send_byte(c, acks[0]);
        i2c_stop();
    endtask

    task automatic read_reg(input logic [6:0] idx, output logic [8:0] val);
        rd_addr = idx;
        #1;
        val = rd_data;
    endtask

    task automatic test_reset();
        logic [8:0] v;
        iRST_N = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        n_checks++;
        if (bus_busy !== 1'b0 || wr_strobe !== 1'b0 || err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b strobe=%b err=%b required 0 0 0", bus_busy, wr_strobe, err_pulse);
        end
        iRST_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        n_checks++;
        if (wr_addr !== 7'h00 || wr_data !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_wr: addr=%h data=%h required 00 000", wr_addr, wr_data);
        end
        n_checks++;
        if (sda_bus !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sda: got %b required 1", sda_bus);
        end
        read_reg(7'd6, v);
        n_checks++;
        if (v !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_reg6: got %h required 000", v);
        end
    endtask

    task automatic test_write();
        logic [2:0] acks;
        logic       a;
        logic [8:0] v;
        int         s0 = n_strobe;
        i2c_start();
        n_checks++;
        if (bus_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_busy: got %b required 1", bus_busy);
        end
        send_byte(8'h34, acks[2]);
        send_byte(8'h0C, acks[1]);
        send_byte(8'h43, acks[0]);
        i2c_stop();
        a = &acks;
        n_checks++;
        if (acks !== 3'b111) begin
            n_fail++;
            $display("FAIL write_acks: got %b required 111 (all=%b)", acks, a);
        end
        n_checks++;
        if (n_strobe - s0 !== 1 || wr_addr !== 7'd6 || wr_data !== 9'h043) begin
            n_fail++;
            $display("FAIL write_commit: strobes=%0d addr=%h data=%h required 1 06 043", n_strobe - s0, wr_addr, wr_data);
        end
        read_reg(7'd6, v);
        n_checks++;
        if (v !== 9'h043) begin
            n_fail++;
            $display("FAIL write_rd6: got %h required 043", v);
        end
        n_checks++;
        if (bus_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_idle: busy=%b required 0", bus_busy);
        end
    endtask

    task automatic test_wrong_addr();
        logic [2:0] acks;
        logic [8:0] v;
        int         s0 = n_strobe;
        write3(8'h80, 8'h0C, 8'h55, acks);
        n_checks++;
        if (acks !== 3'b000) begin
            n_fail++;
            $display("FAIL wrongaddr_acks: got %b required 000", acks);
        end
        n_checks++;
        if (n_strobe - s0 !== 0) begin
            n_fail++;
            $display("FAIL wrongaddr_strobe: got %0d required 0", n_strobe - s0);
        end
        read_reg(7'd6, v);
        n_checks++;
        if (v !== 9'h043) begin
            n_fail++;
            $display("FAIL wrongaddr_rd6: got %h required 043", v);
        end
    endtask

    task automatic test_read_nack();
        logic a;
        int   s0 = n_strobe;
        i2c_start();
        send_byte(8'h35, a);
        n_checks++;
        if (a !== 1'b0) begin
            n_fail++;
            $display("FAIL read_nack: ack=%b required 0", a);
        end
        n_checks++;
        if (bus_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_busy: got %b required 1", bus_busy);
        end
        i2c_stop();
        n_checks++;
        if (bus_busy !== 1'b0 || n_strobe - s0 !== 0) begin
            n_fail++;
            $display("FAIL read_stop: busy=%b strobes=%0d required 0 0", bus_busy, n_strobe - s0);
        end
    endtask

    task automatic test_reset_reg();
        logic [2:0] acks;
        logic [8:0] v;
        int         s0 = n_strobe;
        write3(8'h34, 8'h09, 8'h01, acks);
        read_reg(7'd4, v);
        n_checks++;
        if (acks !== 3'b111 || v !== 9'h101) begin
            n_fail++;
            $display("FAIL rstreg_first: acks=%b reg4=%h required 111 101", acks, v);
        end
        write3(8'h34, 8'h1E, 8'h00, acks);
        read_reg(7'd4, v);
        n_checks++;
        if (v !== 9'h000) begin
            n_fail++;
            $display("FAIL rstreg_reg4: got %h required 000", v);
        end
        read_reg(7'd6, v);
        n_checks++;
        if (v !== 9'h000) begin
            n_fail++;
            $display("FAIL rstreg_reg6: got %h required 000", v);
        end
        n_checks++;
        if (n_strobe - s0 !== 2 || wr_addr !== 7'h0F || wr_data !== 9'h000) begin
            n_fail++;
            $display("FAIL rstreg_commit: strobes=%0d addr=%h data=%h required 2 0f 000", n_strobe - s0, wr_addr, wr_data);
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] acks;
        logic [8:0] v;
        int         s0 = n_strobe;
        int         e0 = n_err;
        write3(8'h34, 8'h20, 8'h12, acks);
        n_checks++;
        if (acks !== 3'b111) begin
            n_fail++;
            $display("FAIL oor_acks: got %b required 111", acks);
        end
        n_checks++;
        if (n_err - e0 !== 1 || n_strobe - s0 !== 1) begin
            n_fail++;
            $display("FAIL oor_pulses: err=%0d strobes=%0d required 1 1", n_err - e0, n_strobe - s0);
        end
        n_checks++;
        if (wr_addr !== 7'h10 || wr_data !== 9'h012) begin
            n_fail++;
            $display("FAIL oor_wr: addr=%h data=%h required 10 012", wr_addr, wr_data);
        end
        read_reg(7'd0, v);
        n_checks++;
        if (v !== 9'h000) begin
            n_fail++;
            $display("FAIL oor_reg0: got %h required 000", v);
        end
        read_reg(7'd16, v);
        n_checks++;
        if (v !== 9'h000) begin
            n_fail++;
            $display("FAIL oor_rd16: got %h required 000", v);
        end
    endtask

    task automatic test_fourth_byte();
        logic [2:0] acks;
        logic       a4;
        logic [8:0] v;
        int         s0 = n_strobe;
        i2c_start();
        send_byte(8'h34, acks[2]);
        send_byte(8'h02, acks[1]);
        send_byte(8'h11, acks[0]);
        send_byte(8'h22, a4);
        i2c_stop();
        n_checks++;
        if (acks !== 3'b111 || a4 !== 1'b0) begin
            n_fail++;
            $display("FAIL fourth_acks: got %b/%b required 111/0", acks, a4);
        end
        read_reg(7'd1, v);
        n_checks++;
        if (v !== 9'h011 || n_strobe - s0 !== 1) begin
            n_fail++;
            $display("FAIL fourth_reg1: reg1=%h strobes=%0d required 011 1", v, n_strobe - s0);
        end
    endtask

    task automatic test_partial();
        logic a;
        int   s0 = n_strobe;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h0C, a);
        i2c_stop();
        n_checks++;
        if (n_strobe - s0 !== 0) begin
            n_fail++;
            $display("FAIL partial_strobe: got %0d required 0", n_strobe - s0);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] acks;
        logic       a;
        logic [8:0] v;
        int         s0 = n_strobe;
        i2c_start();
        send_byte(8'h34, a);
        send_byte(8'h0C, a);
        i2c_start();
        send_byte(8'h34, acks[2]);
        send_byte(8'h0E, acks[1]);
        send_byte(8'h4D, acks[0]);
        i2c_stop();
        read_reg(7'd7, v);
        n_checks++;
        if (acks !== 3'b111 || v !== 9'h04D) begin
            n_fail++;
            $display("FAIL rstart_reg7: acks=%b reg7=%h required 111 04d", acks, v);
        end
        read_reg(7'd6, v);
        n_checks++;
        if (v !== 9'h000 || n_strobe - s0 !== 1) begin
            n_fail++;
            $display("FAIL rstart_reg6: reg6=%h strobes=%0d required 000 1", v, n_strobe - s0);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [2:0] acks;
        logic [8:0] v;
        int         s0;
        i2c_start();
        send_bits(8'h34);
        sda_low = 1'b0;
        wait_q();
        n_checks++;
        if (sda_bus !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ack: sda=%b required 0", sda_bus);
        end
        @(negedge CLOCK_50);
        iRST_N = 1'b0;
        #1;
        n_checks++;
        if (sda_bus !== 1'b1 || bus_busy !== 1'b0 || wr_addr !== 7'h00) begin
            n_fail++;
            $display("FAIL midrst_release: sda=%b busy=%b addr=%h required 1 0 00", sda_bus, bus_busy, wr_addr);
        end
        repeat (3) @(negedge CLOCK_50);
        iRST_N = 1'b1;
        scl = 1'b1;
        repeat (4 * Q) @(negedge CLOCK_50);
        s0 = n_strobe;
        write3(8'h34, 8'h14, 8'h77, acks);
        read_reg(7'd10, v);
        n_checks++;
        if (acks !== 3'b111 || v !== 9'h077 || n_strobe - s0 !== 1) begin
            n_fail++;
            $display("FAIL midrst_write: acks=%b reg10=%h strobes=%0d required 111 077 1", acks, v, n_strobe - s0);
        end
        read_reg(7'd7, v);
        n_checks++;
        if (v !== 9'h000) begin
            n_fail++;
            $display("FAIL midrst_reg7: got %h required 000", v);
        end
    endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    task automatic test_glitch();
        scl = 1'b1;
        sda_low = 1'b0;
        wait_q();
        sda_low = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        sda_low = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        n_checks++;
        if (bus_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b required 0", bus_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read_nack();
        test_reset_reg();
        test_out_of_range();
        test_fourth_byte();
        test_partial();
        test_back_to_back();
        test_reset_mid_ack();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
